// File: rtl/mem_bus_master.sv
// mem_bus_master: core-side initiator for the byte-serial memory bus.
// Converts one RISC-V load/store (funct3 encoded) into a single bus
// transaction, waits for the completion strobe under a watchdog, then
// returns masked and sign/zero-extended load data with done/error status.

module mem_bus_master #(
    parameter int TIMEOUT_CYCLES = 1024,  // must be >= 2
    parameter int CNT_WIDTH      = 11     // must hold TIMEOUT_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // core side
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    // memory bus side
    output logic [31:0] o_bus_data,
    output logic [31:0] o_bus_address,
    output logic        o_bus_DV,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    // The watchdog starts at 0 in the first WAIT cycle; expiring when the
    // count is about to reach TIMEOUT_CYCLES-1 places o_done exactly
    // TIMEOUT_CYCLES cycles after the o_bus_DV cycle.
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 2);

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] wd_cnt;
    logic                 we_q;
    logic [2:0]           funct3_q;
    logic                 err_q;
    logic                 req_legal;
    logic                 wd_expired;

    // Legal encodings: stores SB/SH/SW, loads LB/LH/LW/LBU/LHU.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic legal;
        legal = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~we;
            default:                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Byte-count strobe from the access size in funct3[1:0].
    function automatic logic [2:0] size_to_bhw(input logic [1:0] size);
        logic [2:0] bhw;
        case (size)
            2'b00:   bhw = 3'b001;
            2'b01:   bhw = 3'b010;
            default: bhw = 3'b100;
        endcase
        return bhw;
    endfunction

    // Right-aligned store data with bytes beyond the access size cleared.
    function automatic logic [31:0] mask_wdata(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] m;
        case (size)
            2'b00:   m = {24'h0, w[7:0]};
            2'b01:   m = {16'h0, w[15:0]};
            default: m = w;
        endcase
        return m;
    endfunction

    // Load extension; funct3[2] selects zero extension, stale upper bytes ignored.
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] b);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'h0, b[7:0]}  : {{24{b[7]}}, b[7:0]};
            2'b01:   r = f3[2] ? {16'h0, b[15:0]} : {{16{b[15]}}, b[15:0]};
            default: r = b;
        endcase
        return r;
    endfunction

    assign req_legal  = funct3_legal(i_we, i_funct3);
    assign wd_expired = (wd_cnt == WD_LAST);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential logic uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order across blocks.
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_next = state;
        o_ready    = 1'b0;
        o_done     = 1'b0;
        o_bus_DV   = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_req) begin
                    state_next = req_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                o_bus_DV   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A response in the expiry cycle still completes without error.
                if (i_bus_DV || wd_expired) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_err = o_done & err_q;

    // Request capture, bus drive, watchdog and load-result datapath.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: the datapath registers are reset too, because reset must
        // return every bus and result output to zero immediately.
        if (!i_rst_n) begin
            we_q            <= 1'b0;
            funct3_q        <= 3'b000;
            err_q           <= 1'b0;
            wd_cnt          <= '0;
            o_bus_address   <= 32'h0;
            o_bus_data      <= 32'h0;
            o_bhw           <= 3'b000;
            o_write_notread <= 1'b0;
            o_rdata         <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req) begin
                        we_q     <= i_we;
                        funct3_q <= i_funct3;
                        err_q    <= ~req_legal;
                        // Bus fields change only for a transaction that will
                        // actually be issued; they then hold through WAIT.
                        if (req_legal) begin
                            o_bus_address   <= i_addr;
                            o_bus_data      <= mask_wdata(i_funct3[1:0], i_wdata);
                            o_bhw           <= size_to_bhw(i_funct3[1:0]);
                            o_write_notread <= i_we;
                        end
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    if (i_bus_DV) begin
                        err_q <= 1'b0;
                        if (!we_q) begin
                            o_rdata <= extend_load(funct3_q, i_bus_data);
                        end
                    end else if (wd_expired) begin
                        err_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
